// File: rtl/sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    function automatic logic [31:0] gray(input logic [31:0] x);
        return x ^ (x >> 1);
    endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Counts the cycles a vector has been held; tc flags the last hold cycle.
module sweep_hold_timer #(
    parameter int unsigned HOLD = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // With HOLD=1 the counter never leaves zero, so tc is permanently high.
    assign tc = (cnt == CW'(HOLD - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/compare engine for a small combinational DUT.
// Define SWEEP_GRAY_EN to sweep vectors in Gray-code order instead of ascending binary.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 1,
    parameter int unsigned HOLD  = 100,
    parameter logic [N_OUT*(2**N_IN)-1:0] EXPECT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  vec,
    input  logic [N_OUT-1:0] dut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_cnt,
    output logic             first_err_valid,
    output logic [N_IN-1:0]  first_err_vec
);
    state_t          state, state_next;
    logic [N_IN-1:0] idx, idx_inc, vec_nxt;
    logic [N_OUT-1:0] exp_f;
    logic            tc, launch, sample, timer_clr, timer_en;

    sweep_hold_timer #(.HOLD(HOLD)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .en  (timer_en),
        .tc  (tc)
    );

    assign idx_inc = idx + N_IN'(1);
`ifdef SWEEP_GRAY_EN
    assign vec_nxt = N_IN'(gray(32'(idx_inc)));
`else
    assign vec_nxt = idx_inc;
`endif

    // Expected entry is addressed by the presented vector value, not the sweep index.
    assign exp_f = EXPECT[int'(vec) * N_OUT +: N_OUT];

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = DRIVE;
                    launch     = 1'b1;
                end
            end
            DRIVE: begin
                if (tc) begin
                    sample = 1'b1;
                    if (idx == '1) state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        timer_en  = (state == DRIVE);
        timer_clr = launch || sample;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            vec             <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            state <= state_next;
            if (launch) begin
                idx             <= '0;
                vec             <= '0;
                err_cnt         <= '0;
                first_err_valid <= 1'b0;
                first_err_vec   <= '0;
            end else if (sample) begin
                if (dut_f != exp_f) begin
                    err_cnt <= err_cnt + (N_IN+1)'(1);
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= vec;
                    end
                end
                if (idx != '1) begin
                    idx <= idx_inc;
                    vec <= vec_nxt;
                end
            end
        end
    end

    assign busy = (state == DRIVE);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: a 4-input/HOLD=100 sweeper and a 3-input/2-output/HOLD=1 sweeper.
module tb_truth_table_sweeper;
    localparam int unsigned HOLD_A = 100;
    localparam logic [15:0] EXP_A  = 16'hA5C3;
    localparam logic [15:0] EXP_B  = 16'h9C63;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [15:0] fault_a = '0;

    logic [3:0] vec_a, fevec_a;
    logic [4:0] err_a;
    logic       busy_a, done_a, pass_a, fev_a, dut_fa;
    logic [2:0] vec_b, fevec_b;
    logic [3:0] err_b;
    logic       busy_b, done_b, pass_b, fev_b;
    logic [1:0] dut_fb;

    int checks = 0;
    int errors = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    always #5 clk = ~clk;

    always_comb dut_fa = EXP_A[vec_a] ^ fault_a[vec_a];
    always_comb dut_fb = EXP_B[int'(vec_b)*2 +: 2];

    truth_table_sweeper #(.N_IN(4), .N_OUT(1), .HOLD(HOLD_A), .EXPECT(EXP_A)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .vec(vec_a), .dut_f(dut_fa),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .first_err_valid(fev_a), .first_err_vec(fevec_a)
    );

    truth_table_sweeper #(.N_IN(3), .N_OUT(2), .HOLD(1), .EXPECT(EXP_B)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .vec(vec_b), .dut_f(dut_fb),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .first_err_valid(fev_b), .first_err_vec(fevec_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ord(input int unsigned i);
`ifdef SWEEP_GRAY_EN
        return 32'(i ^ (i >> 1));
`else
        return 32'(i);
`endif
    endfunction

    task automatic run_a(input logic [15:0] mask, input int abort_at);
        int n = 0;
        int exp_err = 0;
        logic [31:0] exp_first = '0;
        logic [31:0] cur = '0;
        fault_a = mask;
        for (int unsigned i = 0; i < 16; i++) begin
            q_a.push_back(ord(i));
            if (mask[ord(i)]) begin
                if (exp_err == 0) exp_first = ord(i);
                exp_err++;
            end
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("a_busy_on", busy_a, 1);
        check("a_err_clr", err_a, 0);
        check("a_fev_clr", fev_a, 0);
        while (busy_a === 1'b1 && n < 2000 && !(abort_at != 0 && n == abort_at)) begin
            if (n % HOLD_A == 0) begin
                if (q_a.size() == 0) check("a_q_empty", 1, 0);
                else cur = q_a.pop_front();
                check("a_vec_first", vec_a, cur);
            end
            if (n % HOLD_A == HOLD_A - 1) check("a_vec_last", vec_a, cur);
            n++;
            @(negedge clk);
        end
        if (abort_at != 0) begin
            check("a_abort_pt", n, abort_at);
            check("a_err_pre", err_a, 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_vec", vec_a, 0);
            check("rst_busy", busy_a, 0);
            check("rst_done", done_a, 0);
            check("rst_pass", pass_a, 0);
            check("rst_err", err_a, 0);
            check("rst_fev", fev_a, 0);
            check("rst_fevec", fevec_a, 0);
            q_a.delete();
            @(negedge clk);
            check("rst_idle", busy_a, 0);
        end else begin
            check("a_sweep_len", n, 16 * HOLD_A);
            check("a_q_drained", q_a.size(), 0);
            check("a_done", done_a, 1);
            check("a_busy_off", busy_a, 0);
            check("a_pass", pass_a, exp_err == 0);
            check("a_err_cnt", err_a, exp_err);
            check("a_fev", fev_a, exp_err != 0);
            check("a_fevec", fevec_a, exp_first);
            check("a_vec_hold", vec_a, ord(15));
            q_a.delete();
        end
    endtask

    task automatic run_b();
        int n = 0;
        for (int unsigned i = 0; i < 8; i++) q_b.push_back(ord(i));
        start_b = 1'b1;
        @(negedge clk);
        while (busy_b === 1'b1 && n < 50) begin
            if (q_b.size() == 0) check("b_q_empty", 1, 0);
            else check("b_vec", vec_b, q_b.pop_front());
            n++;
            @(negedge clk);
        end
        start_b = 1'b0;
        check("b_sweep_len", n, 8);
        check("b_done", done_b, 1);
        check("b_pass", pass_b, 1);
        check("b_err_cnt", err_b, 0);
        check("b_fev", fev_b, 0);
        @(negedge clk);
        check("b_done_stay", done_b, 1);
        q_b.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("init_vec", vec_a, 0);
        check("init_busy", busy_a, 0);
        check("init_done", done_a, 0);
        check("init_pass", pass_a, 0);
        check("init_err", err_a, 0);
        check("init_fev", fev_a, 0);
        run_a(16'h0000, 0);
        run_a(16'h0820, 0);
        run_a(16'h0000, 0);
        run_a(16'h0820, 700);
        run_a(16'h0820, 0);
        run_a(16'h0240, 0);
        run_b();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-checking exhaustive stimulus engine for small combinational DUTs; synthesizable successor to the fixed hand-written 4-input, 100-time-unit sweep benches.
- Drives every input vector of an N_IN-input, N_OUT-output DUT, holds each vector HOLD cycles, samples the DUT response and compares it with a parameterised expected truth table.
- Reports error count, first failing vector, and pass/done status; usable on-board and in simulation.

Parameters:
- N_IN, 4, DUT input count; vectors 0..2^N_IN-1.
- N_OUT, 1, DUT output width.
- HOLD, 100, cycles each vector is held (>=1); sampled on last hold cycle.
- EXPECT, 0, expected table, N_OUT*2^N_IN bits; entry for vector v = EXPECT[v*N_OUT +: N_OUT].

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a sweep when not busy.
- vec  out  N_IN  vector driven to DUT inputs.
- dut_f  in  N_OUT  DUT response.
- busy  out  1  high while sweeping.
- done  out  1  high from sweep end until next start/reset.
- pass  out  1  done && err_cnt==0.
- err_cnt  out  N_IN+1  mismatching vector count (max 2^N_IN, no saturation needed).
- first_err_valid  out  1  at least one mismatch recorded.
- first_err_vec  out  N_IN  first mismatching vector value.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; vec=0, busy=0, done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_vec=0; index and hold counters 0. Reset mid-sweep aborts immediately, no partial result kept.
- FSM: IDLE, DRIVE, DONE.
- IDLE/DONE + start=1: next cycle DRIVE, busy=1, done=0, index=0, hold=0, err_cnt, first_err_* cleared.
- start ignored in DRIVE.
- DRIVE: vec = f(index) registered, stable for exactly HOLD cycles. hold increments each cycle. When hold==HOLD-1: compare dut_f with EXPECT entry for vec. Mismatch: err_cnt+1; if first_err_valid=0, capture vec, set first_err_valid.
- Then if index==2^N_IN-1: next DONE; else index+1, hold=0.
- Sweep length exactly 2^N_IN*HOLD cycles in DRIVE; done=1, busy=0 on the following cycle. vec holds last vector in DONE.
- HOLD=1: sample in the same cycle the vector is presented (combinational DUT assumed settled).
- Default order: f(index)=index, ascending.

Optional Feature:
- SWEEP_GRAY_EN defined: f(index)=index^(index>>1); consecutive vectors differ in one bit; expected entry still indexed by vec value, not index; first_err_vec reports vec value.
- Undefined: ascending binary order; no gray logic synthesised.

Decomposition:
- Package sweeper_pkg: state enum (IDLE, DRIVE, DONE), function gray(x).
- One sub-module, sweep_hold_timer: HOLD-cycle counter with clear and terminal-count output; all other logic in top.

Test Plan:
- N_IN=4, HOLD=100, EXPECT=16'hA5C3, behavioural DUT equal to table; pulse start -> busy 1600 cycles, then done=1, pass=1, err_cnt=0, vec steps 0..15 every 100 cycles.
- Same, DUT output inverted for vec=5 and vec=11 -> err_cnt=2, first_err_vec=5, first_err_valid=1, pass=0.
- HOLD=1, N_IN=3, N_OUT=2, correct DUT -> done after exactly 8 DRIVE cycles, pass=1; start held high in DRIVE has no effect.
- rst=1 at cycle 700 of a sweep -> next cycle all outputs 0, IDLE; new start gives full 1600-cycle sweep.
- start in DONE after failing run with fixed DUT -> err_cnt, first_err_valid cleared at start; pass=1.
- SWEEP_GRAY_EN, N_IN=4 -> vec order 0,1,3,2,6,7,5,4,...,8; single-bit changes; fault on vec=6 -> first_err_vec=6.
